// File: rtl/dec_instr_stim_gen.sv
// Instruction-stream generator for the decoder bench: LFSR-scrambled or swept
// RV32 words over a valid/ready handshake, with a system-class word every SYS_PERIOD-th transaction.
module dec_instr_stim_gen #(
    parameter int          NUM_TRANS  = 10,
    parameter int          SYS_PERIOD = 3,
    parameter int          GAP_CYCLES = 1,
    parameter logic [31:0] SEED       = 32'h1,
    parameter int          CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic             instr_ready_i,
    output logic [31:0]      instr_o,
    output logic             instr_valid_o,
    output logic             sys_o,
    output logic [CNT_W-1:0] count_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESENT = 2'd1,
        S_GAP     = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [31:0]      POLY       = 32'h80200003;
    localparam logic [31:0]      SEED_C     = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam int               PW         = $clog2(SYS_PERIOD + 1);
    localparam logic [PW-1:0]    PHASE_LAST = PW'(SYS_PERIOD - 1);
    localparam logic [CNT_W-1:0] NUM_C      = CNT_W'(NUM_TRANS);
    localparam logic [3:0]       GAP_LAST   = 4'(GAP_CYCLES - 1);

    state_t           state_q, state_d;
    logic [31:0]      lfsr_q, lfsr_d, lfsr_adv;
    logic [31:0]      instr_q, word;
    logic             sys_q, is_sys;
    logic [CNT_W-1:0] count_q, count_d, count_inc;
    logic             mode_q, mode_d, gen_mode;
    logic [3:0]       gap_q, gap_d;
    logic [PW-1:0]    phase_q, phase_base, phase_n;
    logic [2:0]       tidx_q, tidx_base, tidx_n;
    logic [2:0]       sidx_q, sidx_base, sidx_n;
    logic             first, gen;
    logic [2:0]       rnd_idx, f3;
    logic [31:0]      typ_word;

    function automatic logic [31:0] sys_tmpl(input logic [2:0] idx);
        case (idx)
            3'd0:    return 32'h0FFFFFFF;
            3'd1:    return 32'h10500073;
            3'd2:    return 32'h00000073;
            3'd3:    return 32'h00100073;
            3'd4:    return 32'h7B200073;
            default: return 32'h30200073;
        endcase
    endfunction

    // Typed order: JAL, BRANCH, STORE, LUI, OP-IMM, LOAD.
    function automatic logic [31:0] typ_tmpl(input logic [2:0] idx);
        case (idx)
            3'd0:    return 32'h0D90006F;
            3'd1:    return 32'h06000063;
            3'd2:    return 32'h00018023;
            3'd3:    return 32'h00307037;
            3'd4:    return 32'hE000C113;
            default: return 32'h00002003;
        endcase
    endfunction

    function automatic logic [2:0] inc6(input logic [2:0] x);
        return (x == 3'd5) ? 3'd0 : x + 3'd1;
    endfunction

    // Word generation: everything here is the candidate for the next presented word;
    // it is only committed to the registers on edges where gen is set.
    always_comb begin
        lfsr_adv   = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : 32'h0);
        first      = (state_q == S_IDLE) || (state_q == S_DONE);
        gen_mode   = first ? mode_i : mode_q;
        phase_base = first ? '0 : phase_q;
        tidx_base  = first ? 3'd0 : tidx_q;
        sidx_base  = first ? 3'd0 : sidx_q;
        phase_n    = (phase_base == PHASE_LAST) ? '0 : phase_base + PW'(1);
        is_sys     = (phase_n == '0);
        tidx_n     = is_sys ? tidx_base : inc6(tidx_base);
        sidx_n     = is_sys ? inc6(sidx_base) : sidx_base;
        lfsr_d     = gen_mode ? lfsr_q : lfsr_adv;

        case (lfsr_adv[2:0])
            3'd6:    rnd_idx = 3'd0;
            3'd7:    rnd_idx = 3'd1;
            default: rnd_idx = lfsr_adv[2:0];
        endcase

        f3 = lfsr_adv[10:8];
        case (rnd_idx)
            3'd1: if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd1;
            3'd2: if (f3 > 3'd2) f3 = 3'd2;
            3'd4: if (f3 == 3'd1 || f3 == 3'd5) f3 = 3'd3;
            3'd5: if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) f3 = 3'd4;
            default: f3 = f3;
        endcase

        typ_word = typ_tmpl(rnd_idx);
        if (gen_mode) begin
            word = is_sys ? sys_tmpl(sidx_base) : typ_tmpl(tidx_base);
        end else if (is_sys) begin
            word = sys_tmpl(rnd_idx);
        end else begin
            word = {lfsr_adv[27:11], f3, lfsr_adv[7:3], typ_word[6:0]};
        end
    end

    // Handshake: a word is offered while instr_valid_o is high (PRESENT) and is
    // transferred on a rising edge where instr_ready_i is also high; until then
    // instr_o and sys_o do not change.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        mode_d    = mode_q;
        gap_d     = gap_q;
        gen       = 1'b0;
        count_inc = (&count_q) ? count_q : count_q + CNT_W'(1);
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    count_d = '0;
                    mode_d  = mode_i;
                    gen     = 1'b1;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (instr_ready_i) begin
                    count_d = count_inc;
                    if (NUM_TRANS != 0 && count_inc == NUM_C) begin
                        state_d = S_DONE;
                    end else if (GAP_CYCLES == 0) begin
                        gen = 1'b1;
                    end else begin
                        gap_d   = GAP_LAST;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == 4'd0) begin
                    gen     = 1'b1;
                    state_d = S_PRESENT;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q  <= SEED_C;
            instr_q <= '0;
            sys_q   <= 1'b0;
            count_q <= '0;
            mode_q  <= 1'b0;
            gap_q   <= '0;
            phase_q <= '0;
            tidx_q  <= '0;
            sidx_q  <= '0;
        end else begin
            count_q <= count_d;
            mode_q  <= mode_d;
            gap_q   <= gap_d;
            if (gen) begin
                lfsr_q  <= lfsr_d;
                instr_q <= word;
                sys_q   <= is_sys;
                phase_q <= phase_n;
                tidx_q  <= tidx_n;
                sidx_q  <= sidx_n;
            end
        end
    end

    assign instr_o       = instr_q;
    assign sys_o         = sys_q;
    assign count_o       = count_q;
    assign instr_valid_o = (state_q == S_PRESENT);
    assign busy_o        = (state_q == S_PRESENT) || (state_q == S_GAP);
    assign done_o        = (state_q == S_DONE);
    assign state_o       = state_q;

endmodule

// File: tb/tb_dec_instr_stim_gen.sv
// Directed bench for dec_instr_stim_gen: sweep table, backpressure, reset/restart,
// long random legality run and a saturating, gap-2, all-system configuration.
`timescale 1ns/1ps
module tb_dec_instr_stim_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: bounded run of 6, gap 1, system every 3rd word
    logic        a_rst, a_start, a_mode, a_ready;
    logic [31:0] a_instr;
    logic        a_valid, a_sys, a_busy, a_done;
    logic [15:0] a_count;
    logic [1:0]  a_state;

    // Instance B: unbounded, back-to-back
    logic        b_rst, b_start, b_mode, b_ready;
    logic [31:0] b_instr;
    logic        b_valid, b_sys, b_busy, b_done;
    logic [15:0] b_count;
    logic [1:0]  b_state;

    // Instance C: unbounded, 4-bit count, gap 2, every word system-class, seed 0
    logic        c_start, c_mode, c_ready;
    logic [31:0] c_instr;
    logic        c_valid, c_sys, c_busy, c_done;
    logic [3:0]  c_count;
    logic [1:0]  c_state;

    dec_instr_stim_gen #(.NUM_TRANS(6), .SYS_PERIOD(3), .GAP_CYCLES(1), .SEED(32'h1), .CNT_W(16)) u_a (
        .clk_i(clk), .rst_i(a_rst), .start_i(a_start), .mode_i(a_mode), .instr_ready_i(a_ready),
        .instr_o(a_instr), .instr_valid_o(a_valid), .sys_o(a_sys), .count_o(a_count),
        .busy_o(a_busy), .done_o(a_done), .state_o(a_state));

    dec_instr_stim_gen #(.NUM_TRANS(0), .SYS_PERIOD(3), .GAP_CYCLES(0), .SEED(32'h1), .CNT_W(16)) u_b (
        .clk_i(clk), .rst_i(b_rst), .start_i(b_start), .mode_i(b_mode), .instr_ready_i(b_ready),
        .instr_o(b_instr), .instr_valid_o(b_valid), .sys_o(b_sys), .count_o(b_count),
        .busy_o(b_busy), .done_o(b_done), .state_o(b_state));

    dec_instr_stim_gen #(.NUM_TRANS(0), .SYS_PERIOD(1), .GAP_CYCLES(2), .SEED(32'h0), .CNT_W(4)) u_c (
        .clk_i(clk), .rst_i(b_rst), .start_i(c_start), .mode_i(c_mode), .instr_ready_i(c_ready),
        .instr_o(c_instr), .instr_valid_o(c_valid), .sys_o(c_sys), .count_o(c_count),
        .busy_o(c_busy), .done_o(c_done), .state_o(c_state));

    logic [31:0] sys_tab[6] = '{32'h0FFFFFFF, 32'h10500073, 32'h00000073,
                                32'h00100073, 32'h7B200073, 32'h30200073};
    logic [31:0] typ_tab[6] = '{32'h0D90006F, 32'h06000063, 32'h00018023,
                                32'h00307037, 32'hE000C113, 32'h00002003};

    typedef struct {
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic        exp_sys;
        logic [15:0] exp_count;
        logic        exp_done;
        logic        exp_busy;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] s, input logic sys);
        logic [2:0]  idx;
        logic [2:0]  f;
        logic [31:0] t;
        idx = s[2:0];
        if (idx == 3'd6) idx = 3'd0;
        else if (idx == 3'd7) idx = 3'd1;
        if (sys) return sys_tab[idx];
        f = s[10:8];
        if (idx == 3'd1 && (f == 3'd2 || f == 3'd3)) f = 3'd1;
        if (idx == 3'd2 && f > 3'd2) f = 3'd2;
        if (idx == 3'd4 && (f == 3'd1 || f == 3'd5)) f = 3'd3;
        if (idx == 3'd5 && (f == 3'd3 || f >= 3'd6)) f = 3'd4;
        t = typ_tab[idx];
        return {s[27:11], f, s[7:3], t[6:0]};
    endfunction

    // Independent of the template tables: judge funct3 from the opcode alone.
    function automatic logic f3_legal(input logic [31:0] w);
        logic [2:0] f;
        f = w[14:12];
        case (w[6:0])
            7'h63:   return !(f == 3'd2 || f == 3'd3);
            7'h13:   return !(f == 3'd1 || f == 3'd5);
            7'h03:   return !(f == 3'd3 || f == 3'd6 || f == 3'd7);
            7'h23:   return f <= 3'd2;
            default: return 1'b1;
        endcase
    endfunction

    // Waits for A's next valid word, at most 4 falling edges.
    task automatic wait_a_valid();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            a_start = 1'b0;
            n++;
        end while (!a_valid && n < 4);
        check("a_wait_valid", a_valid, 1);
    endtask

    initial begin
        logic [31:0] m_s;
        logic [31:0] exp_w;
        logic [31:0] w1;
        int          n;

        tbl[0]  = '{1'b1, 1'b1, 32'h0D90006F, 1'b0, 16'd0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,        1'b0, 16'd1, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 32'h06000063, 1'b0, 16'd1, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,        1'b0, 16'd2, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 32'h0FFFFFFF, 1'b1, 16'd2, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 32'h0,        1'b0, 16'd3, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 32'h00018023, 1'b0, 16'd3, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,        1'b0, 16'd4, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 32'h00307037, 1'b0, 16'd4, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 32'h0,        1'b0, 16'd5, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 32'h10500073, 1'b1, 16'd5, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 32'h0,        1'b0, 16'd6, 1'b1, 1'b0};

        a_rst = 1'b1; a_start = 1'b0; a_mode = 1'b0; a_ready = 1'b0;
        b_rst = 1'b1; b_start = 1'b0; b_mode = 1'b0; b_ready = 1'b0;
        c_start = 1'b0; c_mode = 1'b0; c_ready = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_valid", a_valid, 0);
        check("rst_instr", a_instr, 0);
        check("rst_sys",   a_sys,   0);
        check("rst_count", a_count, 0);
        check("rst_busy",  a_busy,  0);
        check("rst_done",  a_done,  0);
        check("rst_state", a_state, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_c_count", c_count, 0);
        a_rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);
        check("idle_state", a_state, 0);

        // Sweep run; mode is changed right after start to show it was latched.
        a_start = 1'b1; a_mode = 1'b1;
        for (int i = 0; i < 12; i++) begin
            a_ready = tbl[i].ready;
            @(negedge clk);
            a_start = 1'b0; a_mode = 1'b0;
            check($sformatf("sweep%0d_valid", i), a_valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid) begin
                check($sformatf("sweep%0d_instr", i), a_instr, tbl[i].exp_instr);
                check($sformatf("sweep%0d_sys", i), a_sys, tbl[i].exp_sys);
            end
            check($sformatf("sweep%0d_count", i), a_count, tbl[i].exp_count);
            check($sformatf("sweep%0d_done", i), a_done, tbl[i].exp_done);
            check($sformatf("sweep%0d_busy", i), a_busy, tbl[i].exp_busy);
        end

        // Restart from DONE under backpressure.
        a_start = 1'b1; a_mode = 1'b1; a_ready = 1'b0;
        @(negedge clk);
        a_start = 1'b0;
        check("bp_count_cleared", a_count, 0);
        check("bp_done_low", a_done, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", a_valid, 1);
            check("bp_instr", a_instr, 32'h0D90006F);
            check("bp_sys",   a_sys,   0);
            check("bp_count", a_count, 0);
        end
        a_ready = 1'b1;
        @(negedge clk);
        a_ready = 1'b0;
        check("bp_accept_count", a_count, 1);
        check("bp_accept_gap", a_state, 2);
        @(negedge clk);
        check("bp_word2", a_instr, 32'h06000063);

        // A start pulse while presenting word 2 must not restart the run.
        a_start = 1'b1; a_mode = 1'b0;
        @(negedge clk);
        a_start = 1'b0;
        check("ign_start_instr", a_instr, 32'h06000063);
        check("ign_start_count", a_count, 1);
        check("ign_start_state", a_state, 1);

        a_ready = 1'b1;
        n = 0;
        while (a_count != 16'd4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("midrun_count4", a_count, 4);
        a_rst = 1'b1;
        @(negedge clk);
        a_rst = 1'b0;
        check("midrun_rst_valid", a_valid, 0);
        check("midrun_rst_count", a_count, 0);
        check("midrun_rst_state", a_state, 0);

        // Random run from a fresh seed.
        m_s = 32'h1; w1 = 32'h0;
        a_start = 1'b1; a_mode = 1'b0; a_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            wait_a_valid();
            m_s = lfsr_next(m_s);
            exp_w = model_word(m_s, (k % 3) == 0);
            if (k == 1) begin
                w1 = exp_w;
                check("rand_first_word", a_instr, 32'h02000037);
            end
            check($sformatf("rand1_w%0d", k), a_instr, exp_w);
            check($sformatf("rand1_s%0d", k), a_sys, ((k % 3) == 0));
        end
        @(negedge clk);
        check("rand1_done", a_done, 1);
        check("rand1_count", a_count, 6);

        // Restart from DONE: LFSR continues, so the first word differs.
        a_start = 1'b1; a_mode = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            wait_a_valid();
            m_s = lfsr_next(m_s);
            exp_w = model_word(m_s, (k % 3) == 0);
            check($sformatf("rand2_w%0d", k), a_instr, exp_w);
            if (k == 1) begin
                checks++;
                if (a_instr === w1) begin
                    errors++;
                    $display("FAIL rand2_differs: got %h required not %h", a_instr, w1);
                end
                check("rand2_count_cleared", a_count, 0);
            end
        end

        // Reset mid-run, then the same sequence must come out again.
        a_rst = 1'b1;
        @(negedge clk);
        a_rst = 1'b0;
        check("rerun_rst_valid", a_valid, 0);
        m_s = 32'h1;
        a_start = 1'b1; a_mode = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            wait_a_valid();
            m_s = lfsr_next(m_s);
            exp_w = model_word(m_s, (k % 3) == 0);
            if (k == 1) check("rerun_first_word", a_instr, 32'h02000037);
            check($sformatf("rerun_w%0d", k), a_instr, exp_w);
        end
        a_ready = 1'b0;

        // 1000 back-to-back accepts in random mode.
        m_s = 32'h1;
        b_start = 1'b1; b_mode = 1'b0; b_ready = 1'b1;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            b_start = 1'b0;
            m_s = lfsr_next(m_s);
            exp_w = model_word(m_s, (k % 3) == 0);
            check("b_valid", b_valid, 1);
            check($sformatf("b_w%0d", k), b_instr, exp_w);
            check("b_sys", b_sys, ((k % 3) == 0));
            check("b_count", b_count, 32'(k - 1));
            if (!b_sys) check($sformatf("b_f3_legal%0d", k), 32'(f3_legal(b_instr)), 1);
        end
        @(negedge clk);
        b_ready = 1'b0;
        check("b_count_1000", b_count, 1000);
        check("b_not_done", b_done, 0);

        // Seed 0 behaves as 1; every word system-class; two idle cycles; 4-bit count saturates.
        m_s = 32'h1;
        c_start = 1'b1; c_mode = 1'b0; c_ready = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                c_start = 1'b0;
                n++;
            end while (!c_valid && n < 5);
            check("c_valid", c_valid, 1);
            if (k > 1) check("c_gap_len", n, 3);
            m_s = lfsr_next(m_s);
            if (k == 1) check("c_first_word", c_instr, 32'h00100073);
            check($sformatf("c_w%0d", k), c_instr, model_word(m_s, 1'b1));
            check("c_sys", c_sys, 1);
            check("c_count", c_count, (k - 1 > 15) ? 32'd15 : 32'(k - 1));
        end
        @(negedge clk);
        c_ready = 1'b0;
        check("c_count_sat", c_count, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
